// File: rtl/sd_img_loader_if.sv
// Purpose: bundles the SD user read port, the control/status lines and the
// pixel stream of sd_img_loader into one interface.
//   master : the loader side (drives requests, pixel stream and status)
//   slave  : the environment side (SD controller, control source, consumer)
interface sd_img_loader_if;
    logic        sd_init_done;
    logic        load_start;
    logic        rd_start_en;
    logic [31:0] rd_sec_addr;
    logic        rd_busy;
    logic        rd_val_en;
    logic [15:0] rd_val_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic        pix_last;
    logic        load_busy;
    logic        load_done;
    logic [1:0]  err_sticky;

    modport master (
        input  sd_init_done, load_start, rd_busy, rd_val_en, rd_val_data, pix_ready,
        output rd_start_en, rd_sec_addr, pix_valid, pix_data, pix_last,
               load_busy, load_done, err_sticky
    );

    modport slave (
        output sd_init_done, load_start, rd_busy, rd_val_en, rd_val_data, pix_ready,
        input  rd_start_en, rd_sec_addr, pix_valid, pix_data, pix_last,
               load_busy, load_done, err_sticky
    );
endinterface

// File: rtl/sd_img_loader.sv
// Purpose: reads SEC_NUM consecutive 256-word sectors starting at START_SEC
// from the SD controller user read port, buffers the words in a first-word
// fall-through FIFO and presents them as a valid/ready pixel stream.
// A sector is requested only when the FIFO has room for all of it, because
// the SD read stream cannot be stalled once started.
// Ports:
//   clk_ref : system clock (SD controller user-side clock)
//   rst     : asynchronous active-high reset
//   ldr     : sd_img_loader_if.master -- load control, SD read port,
//             pixel stream and status (load_busy, load_done, err_sticky)
module sd_img_loader #(
    parameter logic [31:0] START_SEC = 32'd8192,
    parameter int unsigned SEC_NUM   = 1200,
    parameter int unsigned FIFO_AW   = 10
) (
    input  logic             clk_ref,
    input  logic             rst,
    sd_img_loader_if.master  ldr
);

    localparam int unsigned DEPTH     = 2 ** FIFO_AW;
    localparam int unsigned CNT_W     = FIFO_AW + 1;
    localparam int unsigned SEC_WORDS = 256;
    localparam int unsigned TOTAL     = SEC_NUM * SEC_WORDS;
    localparam int unsigned OUT_W     = $clog2(TOTAL) + 1;
    localparam int unsigned SEC_W     = $clog2(SEC_NUM + 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_INIT  = 3'd1;
    localparam logic [2:0] S_WAIT_SPACE = 3'd2;
    localparam logic [2:0] S_REQ        = 3'd3;
    localparam logic [2:0] S_WAIT_HI    = 3'd4;
    localparam logic [2:0] S_WAIT_LO    = 3'd5;
    localparam logic [2:0] S_DONE       = 3'd6;

    logic [2:0]         state_q, state_d;
    logic [SEC_W-1:0]   sec_cnt_q, sec_cnt_d;
    logic [8:0]         word_cnt_q, word_cnt_d;
    logic [8:0]         word_inc;
    logic [OUT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [1:0]         err_q, err_d;
    logic [31:0]        addr_q, addr_d;
    logic               start_en_q, start_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic [15:0]        data_q, data_d;
    logic [15:0]        mem [DEPTH];

    logic               accept;
    logic               pop;
    logic               push;
    logic               full;
    logic               push_ok;

    assign accept  = (state_q == S_IDLE) && ldr.load_start;
    assign pop     = valid_q && ldr.pix_ready;
    assign push    = (state_q == S_WAIT_LO) && ldr.rd_val_en;
    assign full    = (cnt_q == CNT_W'(DEPTH));
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign push_ok = push && (!full || pop);

    // Next-state, counters, status and FIFO bookkeeping.
    always_comb begin
        state_d    = state_q;
        sec_cnt_d  = sec_cnt_q;
        word_cnt_d = word_cnt_q;
        word_inc   = word_cnt_q + 9'(ldr.rd_val_en);
        out_cnt_d  = out_cnt_q;
        err_d      = err_q;
        addr_d     = addr_q;
        start_en_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        valid_d    = 1'b0;
        last_d     = 1'b0;
        data_d     = data_q;

        case (state_q)
            S_IDLE: begin
                if (ldr.load_start) begin
                    state_d    = S_WAIT_INIT;
                    sec_cnt_d  = '0;
                    word_cnt_d = '0;
                    err_d      = 2'b00;
                end
            end
            S_WAIT_INIT: begin
                if (ldr.sd_init_done) begin
                    state_d = S_WAIT_SPACE;
                end
            end
            S_WAIT_SPACE: begin
                // Room for a whole sector means count <= DEPTH - 256.
                if (cnt_q <= CNT_W'(DEPTH - SEC_WORDS)) begin
                    state_d = S_REQ;
                    addr_d  = START_SEC + 32'(sec_cnt_q);
                end
            end
            S_REQ: begin
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (ldr.rd_busy) begin
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                word_cnt_d = word_inc;
                if (!ldr.rd_busy) begin
                    if (word_inc != 9'(SEC_WORDS)) begin
                        err_d[0] = 1'b1;
                    end
                    word_cnt_d = '0;
                    sec_cnt_d  = sec_cnt_q + SEC_W'(1);
                    state_d    = (sec_cnt_q == SEC_W'(SEC_NUM - 1)) ? S_DONE : S_WAIT_SPACE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (push && !push_ok) begin
            err_d[1] = 1'b1;
        end

        start_en_d = (state_d == S_REQ);
        busy_d     = (state_d == S_WAIT_INIT) || (state_d == S_WAIT_SPACE) ||
                     (state_d == S_REQ) || (state_d == S_WAIT_HI) || (state_d == S_WAIT_LO);
        done_d     = (state_d == S_DONE);

        wr_ptr_d = wr_ptr_q + FIFO_AW'(push_ok);
        rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);
        cnt_d    = cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
        valid_d  = (cnt_d != '0);
        // Registered head: bypass the incoming word when it becomes the head.
        data_d   = (push_ok && (wr_ptr_q == rd_ptr_d)) ? ldr.rd_val_data : mem[rd_ptr_d];

        // Accepted-word counter saturates at TOTAL so stray words are never flagged.
        if (accept) begin
            out_cnt_d = '0;
        end else if (pop && (out_cnt_q != OUT_W'(TOTAL))) begin
            out_cnt_d = out_cnt_q + OUT_W'(1);
        end
        last_d = valid_d && (out_cnt_d == OUT_W'(TOTAL - 1));
    end

    // State and registered outputs.
    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sec_cnt_q  <= '0;
            word_cnt_q <= '0;
            out_cnt_q  <= '0;
            err_q      <= 2'b00;
            addr_q     <= START_SEC;
            start_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            sec_cnt_q  <= sec_cnt_d;
            word_cnt_q <= word_cnt_d;
            out_cnt_q  <= out_cnt_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            start_en_q <= start_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            data_q     <= data_d;
        end
    end

    // FIFO storage; contents need no reset, validity is tracked by cnt_q.
    always_ff @(posedge clk_ref) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= ldr.rd_val_data;
        end
    end

    assign ldr.rd_start_en = start_en_q;
    assign ldr.rd_sec_addr = addr_q;
    assign ldr.pix_valid   = valid_q;
    assign ldr.pix_data    = data_q;
    assign ldr.pix_last    = last_q;
    assign ldr.load_busy   = busy_q;
    assign ldr.load_done   = done_q;
    assign ldr.err_sticky  = err_q;

endmodule

// File: tb/tb_sd_img_loader.sv
// Bench for sd_img_loader with SEC_NUM=3 (768 words per image) and
// FIFO_AW=9 (512-word FIFO). A behavioural SD read model answers each
// request with 256 words whose value is (sector offset * 256 + word index),
// so the k-th word of an image must read k.
module tb_sd_img_loader;

    localparam logic [31:0] START = 32'd8192;
    localparam int          NWORDS = 768;

    logic clk;
    logic rst;
    sd_img_loader_if ldr ();

    sd_img_loader #(
        .START_SEC (START),
        .SEC_NUM   (3),
        .FIFO_AW   (9)
    ) dut (
        .clk_ref (clk),
        .rst     (rst),
        .ldr     (ldr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model / monitor state (written only by the model process).
    bit          m_active = 1'b0;
    int          m_wait   = 0;
    int          m_left   = 0;
    int          m_idx    = 0;
    logic [31:0] m_addr   = '0;
    int          req_cnt  = 0;
    logic [31:0] req_addr [4];
    int          words_at [4];
    int          n_start_cyc = 0;
    int          out_idx  = 0;
    int          n_bad    = 0;
    int          n_last   = 0;
    int          last_idx = -1;
    int          n_done   = 0;
    // Written only by the stimulus process: request index to shorten to 255 words.
    int          short_at = -1;

    // SD read model and pixel monitor, operating on the falling edge.
    initial begin
        ldr.rd_busy     = 1'b0;
        ldr.rd_val_en   = 1'b0;
        ldr.rd_val_data = 16'h0;
        forever begin
            @(negedge clk);
            if (!rst && ldr.load_start && !ldr.load_busy && !ldr.load_done) begin
                out_idx = 0; n_bad = 0; n_last = 0; last_idx = -1;
                n_done = 0; req_cnt = 0; n_start_cyc = 0;
            end
            if (!rst && ldr.load_done) n_done++;
            if (!rst && ldr.rd_start_en) n_start_cyc++;
            ldr.rd_val_en = 1'b0;
            if (!m_active) begin
                if (!rst && ldr.rd_start_en) begin
                    m_active = 1'b1;
                    m_wait   = 3;
                    m_idx    = 0;
                    m_addr   = ldr.rd_sec_addr;
                    m_left   = (req_cnt == short_at) ? 255 : 256;
                    ldr.rd_busy = 1'b1;
                    if (req_cnt < 4) begin
                        req_addr[req_cnt] = m_addr;
                        words_at[req_cnt] = out_idx;
                    end
                    req_cnt++;
                end
            end else if (m_wait > 0) begin
                m_wait--;
            end else if (m_left > 0) begin
                ldr.rd_val_en   = 1'b1;
                ldr.rd_val_data = 16'((m_addr - START) * 256 + 32'(m_idx));
                m_idx++;
                m_left--;
            end else begin
                ldr.rd_busy = 1'b0;
                m_active    = 1'b0;
            end
            if (!rst && ldr.pix_valid && ldr.pix_ready) begin
                if (ldr.pix_data !== 16'(out_idx)) n_bad++;
                if (ldr.pix_last) begin
                    n_last++;
                    last_idx = out_idx;
                end
                out_idx++;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 ldr.load_start = 1'b1;
        @(posedge clk); #1 ldr.load_start = 1'b0;
    endtask

    // Waits for load completion and FIFO drain; to=1 if the budget expires.
    task automatic wait_done(output bit to);
        to = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (n_done >= 1 && !ldr.load_busy && !m_active && !ldr.pix_valid) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (ldr.rd_start_en !== 1'b0) $display("FAIL reset_start_en got=%b exp=0", ldr.rd_start_en); else n_pass++;
        n_checks++; if (ldr.rd_sec_addr !== START) $display("FAIL reset_addr got=%0d exp=%0d", ldr.rd_sec_addr, START); else n_pass++;
        n_checks++; if (ldr.pix_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", ldr.pix_valid); else n_pass++;
        n_checks++; if (ldr.pix_last !== 1'b0) $display("FAIL reset_last got=%b exp=0", ldr.pix_last); else n_pass++;
        n_checks++; if (ldr.load_busy !== 1'b0 || ldr.load_done !== 1'b0) $display("FAIL reset_busy_done got=%b%b exp=00", ldr.load_busy, ldr.load_done); else n_pass++;
        n_checks++; if (ldr.err_sticky !== 2'b00) $display("FAIL reset_err got=%b exp=00", ldr.err_sticky); else n_pass++;
        n_checks++; if (ldr.pix_data !== 16'h0) $display("FAIL reset_data got=%h exp=0", ldr.pix_data); else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        bit to;
        int n;
        ldr.sd_init_done = 1'b1;
        ldr.pix_ready    = 1'b1;
        pulse_start();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                n_checks++; if (ldr.load_busy !== 1'b1) $display("FAIL basic_busy got=%b exp=1", ldr.load_busy); else n_pass++;
            end
            if (ldr.rd_start_en) break;
            n++;
        end
        n_checks++; if (n > 3) $display("FAIL basic_latency got=%0d exp<=3", n); else n_pass++;
        wait_done(to);
        n_checks++; if (to) $display("FAIL basic_timeout got=1 exp=0"); else n_pass++;
        n_checks++; if (req_cnt != 3 || n_start_cyc != 3) $display("FAIL basic_reqs got=%0d/%0d exp=3/3", req_cnt, n_start_cyc); else n_pass++;
        n_checks++; if (req_addr[0] !== 32'd8192) $display("FAIL basic_addr0 got=%0d exp=8192", req_addr[0]); else n_pass++;
        n_checks++; if (req_addr[1] !== 32'd8193) $display("FAIL basic_addr1 got=%0d exp=8193", req_addr[1]); else n_pass++;
        n_checks++; if (req_addr[2] !== 32'd8194) $display("FAIL basic_addr2 got=%0d exp=8194", req_addr[2]); else n_pass++;
        n_checks++; if (out_idx != NWORDS || n_bad != 0) $display("FAIL basic_words got=%0d bad=%0d exp=768 bad=0", out_idx, n_bad); else n_pass++;
        n_checks++; if (n_last != 1 || last_idx != NWORDS - 1) $display("FAIL basic_last got=%0d@%0d exp=1@767", n_last, last_idx); else n_pass++;
        n_checks++; if (n_done != 1) $display("FAIL basic_done got=%0d exp=1", n_done); else n_pass++;
        n_checks++; if (ldr.err_sticky !== 2'b00) $display("FAIL basic_err got=%b exp=00", ldr.err_sticky); else n_pass++;
    endtask

    task automatic test_wait_init();
        bit to;
        int seen;
        int n;
        ldr.sd_init_done = 1'b0;
        pulse_start();
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (ldr.rd_start_en) seen++;
        end
        n_checks++; if (seen != 0 || req_cnt != 0) $display("FAIL init_noreq got=%0d/%0d exp=0/0", seen, req_cnt); else n_pass++;
        n_checks++; if (ldr.load_busy !== 1'b1) $display("FAIL init_busy got=%b exp=1", ldr.load_busy); else n_pass++;
        @(posedge clk); #1 ldr.sd_init_done = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ldr.rd_start_en) break;
            n++;
        end
        n_checks++; if (n > 2) $display("FAIL init_latency got=%0d exp<=2", n); else n_pass++;
        wait_done(to);
        n_checks++; if (to || out_idx != NWORDS || n_bad != 0) $display("FAIL init_words got=%0d bad=%0d to=%0b exp=768 bad=0", out_idx, n_bad, to); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit to;
        ldr.pix_ready = 1'b0;
        pulse_start();
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (req_cnt == 2 && !m_active) begin
                to = 1'b0;
                break;
            end
        end
        repeat (50) @(negedge clk);
        n_checks++; if (to || req_cnt != 2) $display("FAIL bp_hold got=%0d to=%0b exp=2", req_cnt, to); else n_pass++;
        n_checks++; if (ldr.pix_valid !== 1'b1 || ldr.load_busy !== 1'b1) $display("FAIL bp_state got=%b%b exp=11", ldr.pix_valid, ldr.load_busy); else n_pass++;
        n_checks++; if (ldr.err_sticky !== 2'b00) $display("FAIL bp_err_full got=%b exp=00", ldr.err_sticky); else n_pass++;
        n_checks++; if (ldr.pix_data !== 16'h0) $display("FAIL bp_head got=%h exp=0", ldr.pix_data); else n_pass++;
        @(posedge clk); #1 ldr.pix_ready = 1'b1;
        wait_done(to);
        n_checks++; if (to || req_cnt != 3) $display("FAIL bp_third got=%0d to=%0b exp=3", req_cnt, to); else n_pass++;
        n_checks++; if (words_at[2] < 256 || words_at[2] > 258) $display("FAIL bp_drain got=%0d exp=256..258", words_at[2]); else n_pass++;
        n_checks++; if (out_idx != NWORDS || n_bad != 0 || last_idx != NWORDS - 1) $display("FAIL bp_words got=%0d bad=%0d last=%0d exp=768/0/767", out_idx, n_bad, last_idx); else n_pass++;
        n_checks++; if (ldr.err_sticky !== 2'b00) $display("FAIL bp_err got=%b exp=00", ldr.err_sticky); else n_pass++;
    endtask

    task automatic test_short_sector();
        bit to;
        short_at = 0;
        pulse_start();
        wait_done(to);
        short_at = -1;
        n_checks++; if (to || ldr.err_sticky !== 2'b01) $display("FAIL short_err got=%b to=%0b exp=01", ldr.err_sticky, to); else n_pass++;
        n_checks++; if (req_cnt != 3 || n_done != 1) $display("FAIL short_cont got=%0d/%0d exp=3/1", req_cnt, n_done); else n_pass++;
        n_checks++; if (out_idx != NWORDS - 1 || n_last != 0) $display("FAIL short_words got=%0d last=%0d exp=767/0", out_idx, n_last); else n_pass++;
        pulse_start();
        @(negedge clk);
        n_checks++; if (ldr.err_sticky !== 2'b00) $display("FAIL short_clear got=%b exp=00", ldr.err_sticky); else n_pass++;
        wait_done(to);
        n_checks++; if (to || out_idx != NWORDS || n_bad != 0 || last_idx != NWORDS - 1) $display("FAIL short_next got=%0d bad=%0d last=%0d exp=768/0/767", out_idx, n_bad, last_idx); else n_pass++;
        n_checks++; if (ldr.err_sticky !== 2'b00) $display("FAIL short_next_err got=%b exp=00", ldr.err_sticky); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit to;
        pulse_start();
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (req_cnt == 2 && m_active && m_left < 200) begin
                to = 1'b0;
                break;
            end
        end
        n_checks++; if (to) $display("FAIL mid_reach got=timeout exp=mid-sector"); else n_pass++;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        n_checks++; if (ldr.pix_valid !== 1'b0 || ldr.pix_last !== 1'b0 || ldr.rd_start_en !== 1'b0) $display("FAIL mid_outs got=%b%b%b exp=000", ldr.pix_valid, ldr.pix_last, ldr.rd_start_en); else n_pass++;
        n_checks++; if (ldr.load_busy !== 1'b0 || ldr.load_done !== 1'b0 || ldr.err_sticky !== 2'b00) $display("FAIL mid_status got=%b%b%b exp=0000", ldr.load_busy, ldr.load_done, ldr.err_sticky); else n_pass++;
        n_checks++; if (ldr.rd_sec_addr !== START) $display("FAIL mid_addr got=%0d exp=%0d", ldr.rd_sec_addr, START); else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 1000 && m_active; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        n_checks++; if (ldr.pix_valid !== 1'b0 || ldr.load_busy !== 1'b0) $display("FAIL mid_discard got=%b%b exp=00", ldr.pix_valid, ldr.load_busy); else n_pass++;
        pulse_start();
        wait_done(to);
        n_checks++; if (to || out_idx != NWORDS || n_bad != 0 || last_idx != NWORDS - 1) $display("FAIL mid_reload got=%0d bad=%0d last=%0d exp=768/0/767", out_idx, n_bad, last_idx); else n_pass++;
        n_checks++; if (req_cnt != 3 || req_addr[0] !== START) $display("FAIL mid_reload_req got=%0d@%0d exp=3@8192", req_cnt, req_addr[0]); else n_pass++;
    endtask

    task automatic test_ignore_start();
        bit to;
        pulse_start();
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_cnt == 1) begin
                to = 1'b0;
                break;
            end
        end
        n_checks++; if (to || ldr.load_busy !== 1'b1) $display("FAIL ign_busy got=%b to=%0b exp=1", ldr.load_busy, to); else n_pass++;
        pulse_start();
        wait_done(to);
        n_checks++; if (to || req_cnt != 3 || n_start_cyc != 3) $display("FAIL ign_reqs got=%0d/%0d exp=3/3", req_cnt, n_start_cyc); else n_pass++;
        n_checks++; if (n_done != 1) $display("FAIL ign_done got=%0d exp=1", n_done); else n_pass++;
        n_checks++; if (out_idx != NWORDS || n_bad != 0 || last_idx != NWORDS - 1) $display("FAIL ign_words got=%0d bad=%0d last=%0d exp=768/0/767", out_idx, n_bad, last_idx); else n_pass++;
    endtask

    initial begin
        rst              = 1'b1;
        ldr.sd_init_done = 1'b0;
        ldr.load_start   = 1'b0;
        ldr.pix_ready    = 1'b0;
        test_reset();
        test_basic();
        test_wait_init();
        test_backpressure();
        test_short_sector();
        test_reset_mid();
        test_ignore_start();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
